qspi_read_arbiter: RTL

Read-only QSPI flash controller that shares the external W25Q128-class flash (mprj_io[10:5]) between two requesters: port 0 is the QCPU instruction fetch, port 1 is the data/LDC path. It arbitrates round-robin and issues Fast Read Quad Output (0x6B) transactions: command and address go out single-bit on IO0, data comes back over 4 bits. It sits between wrapped_qcpu and the pad multiplexer.

---
 rtl/qspi_arb_pkg.sv | 39 +++
 rtl/qspi_read_arbiter_rr_arb.sv | 27 ++
 rtl/qspi_read_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: state encoding, pad encodings and phase lengths shared by qspi_read_arbiter.
// ST_HOLD is only present when CONT_READ_EN is defined.
package qspi_arb_pkg;

    localparam int unsigned N_PORTS  = 2;
    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned CMD_CYC  = 16;
    localparam int unsigned ADDR_CYC = 48;
    localparam int unsigned DATA_CYC = 4;

    localparam logic [7:0] CMD_QREAD = 8'h6B;
    localparam logic [3:0] OE_SERIAL = 4'b1101;
    localparam logic [3:0] OE_QUAD   = 4'b0000;
    localparam logic [3:0] DO_IDLE   = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE,
        ST_CSWAIT
`ifdef CONT_READ_EN
        , ST_HOLD
`endif
    } state_e;

    // Last counter value of a phase lasting the given number of clk cycles.
    function automatic logic [CNT_W-1:0] phase_last(input int unsigned cycles);
        return CNT_W'(cycles - 32'd1);
    endfunction

    function automatic logic [CNT_W-1:0] dummy_last(input int unsigned dummy_clks);
        return CNT_W'(32'd2 * dummy_clks - 32'd1);
    endfunction

endpackage

// File: rtl/qspi_read_arbiter_rr_arb.sv
// qspi_rr_arb: two-way round-robin arbiter; combinational grant, last-served updated on upd_i.
module qspi_rr_arb
    import qspi_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_PORTS-1:0] req_i,
    input  logic               upd_i,
    input  logic               upd_port_i,
    output logic               gnt_vld_c_o,
    output logic               gnt_port_c_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_vld_c_o  = |req_i;
        gnt_port_c_o = (&req_i) ? ~last_q : req_i[1];
        last_d       = upd_i ? upd_port_i : last_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= 1'b1;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/qspi_read_arbiter.sv
// qspi_read_arbiter: shares one QSPI flash between two read ports using Fast Read Quad Output (0x6B).
// Define CONT_READ_EN to keep csb low after a read so a sequential next address skips cmd/addr/dummy.
module qspi_read_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned DUMMY_CLKS = 8,
    parameter int unsigned CS_HIGH    = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req0,
    input  logic [23:0] addr0,
    output logic        ack0,
    input  logic        req1,
    input  logic [23:0] addr1,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        qspi_csb,
    output logic        qspi_sclk,
    output logic [3:0]  qspi_do,
    output logic [3:0]  qspi_oe,
    input  logic [3:0]  qspi_di
);

    localparam logic [CNT_W-1:0] CMD_LAST    = phase_last(CMD_CYC);
    localparam logic [CNT_W-1:0] ADDR_LAST   = phase_last(ADDR_CYC);
    localparam logic [CNT_W-1:0] DATA_LAST   = phase_last(DATA_CYC);
    localparam logic [CNT_W-1:0] DUMMY_LAST  = dummy_last(DUMMY_CLKS);
    localparam logic [CNT_W-1:0] CSW_CMD     = phase_last(CS_HIGH);
    localparam logic [CNT_W-1:0] CSW_IDLE    = CNT_W'(CS_HIGH - 32'd2);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         sh_q, sh_d;
    logic                port_q, port_d;
    logic                pend_q, pend_d;
    logic [3:0]          nib_q, nib_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                csb_q, csb_d, sclk_q, sclk_d;
    logic [3:0]          do_q, do_d, oe_q, oe_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic                gnt_vld_c, gnt_port_c, upd_c;
    logic [ADDR_W-1:0]   gnt_addr_c;
`ifdef CONT_READ_EN
    logic [ADDR_W-1:0]   addr_q, addr_d;
`endif

    qspi_rr_arb u_arb (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .req_i        ({req1, req0}),
        .upd_i        (upd_c),
        .upd_port_i   (port_q),
        .gnt_vld_c_o  (gnt_vld_c),
        .gnt_port_c_o (gnt_port_c)
    );

    assign gnt_addr_c = gnt_port_c ? addr1 : addr0;

    // Next-state, phase counter, shifter and capture datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        sh_d    = sh_q;
        port_d  = port_q;
        pend_d  = pend_q;
        nib_d   = nib_q;
        rdata_d = rdata_q;
        upd_c   = 1'b0;
`ifdef CONT_READ_EN
        addr_d  = addr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld_c) begin
                    port_d  = gnt_port_c;
                    sh_d    = {CMD_QREAD, gnt_addr_c};
                    state_d = ST_CMD;
                    cnt_d   = '0;
`ifdef CONT_READ_EN
                    addr_d  = gnt_addr_c;
`endif
                end
            end
            ST_CMD, ST_ADDR: begin
                if (cnt_q[0]) sh_d = {sh_q[30:0], 1'b0};
                if (state_q == ST_CMD && cnt_q == CMD_LAST) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end else if (state_q == ST_ADDR && cnt_q == ADDR_LAST) begin
                    state_d = ST_DUMMY;
                    cnt_d   = '0;
                end
            end
            ST_DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_W'(1)) nib_d = qspi_di;
                if (cnt_q == DATA_LAST) begin
                    rdata_d = {nib_q, qspi_di};
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                upd_c  = 1'b1;
                cnt_d  = '0;
                pend_d = 1'b0;
`ifdef CONT_READ_EN
                state_d = ST_HOLD;
`else
                state_d = (CS_HIGH > 32'd1) ? ST_CSWAIT : ST_IDLE;
`endif
            end
            ST_CSWAIT: begin
                // A pending grant from HOLD waits one cycle longer, then restarts at CMD.
                if (cnt_q == (pend_q ? CSW_CMD : CSW_IDLE)) begin
                    state_d = pend_q ? ST_CMD : ST_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
`ifdef CONT_READ_EN
            ST_HOLD: begin
                if (gnt_vld_c) begin
                    port_d = gnt_port_c;
                    addr_d = gnt_addr_c;
                    cnt_d  = '0;
                    if (gnt_addr_c == addr_q + ADDR_W'(1)) begin
                        state_d = ST_DATA;
                    end else begin
                        sh_d    = {CMD_QREAD, gnt_addr_c};
                        pend_d  = 1'b1;
                        state_d = ST_CSWAIT;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered pad/handshake outputs derived from the upcoming state.
    always_comb begin
        csb_d  = 1'b1;
        sclk_d = 1'b0;
        do_d   = DO_IDLE;
        oe_d   = OE_SERIAL;
        unique case (state_d)
            ST_CMD, ST_ADDR: begin
                csb_d  = 1'b0;
                sclk_d = cnt_d[0];
                do_d   = {DO_IDLE[3:1], sh_d[31]};
            end
            ST_DUMMY, ST_DATA: begin
                csb_d  = 1'b0;
                sclk_d = cnt_d[0];
                oe_d   = OE_QUAD;
            end
`ifdef CONT_READ_EN
            ST_DONE, ST_HOLD: begin
                csb_d = 1'b0;
                oe_d  = OE_QUAD;
            end
`endif
            default: ;
        endcase
        ack0_d = (state_d == ST_DONE) && !port_d;
        ack1_d = (state_d == ST_DONE) &&  port_d;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            port_q  <= 1'b0;
            pend_q  <= 1'b0;
            nib_q   <= '0;
            rdata_q <= '0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            do_q    <= DO_IDLE;
            oe_q    <= OE_SERIAL;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CONT_READ_EN
            addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            port_q  <= port_d;
            pend_q  <= pend_d;
            nib_q   <= nib_d;
            rdata_q <= rdata_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            do_q    <= do_d;
            oe_q    <= oe_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
`ifdef CONT_READ_EN
            addr_q  <= addr_d;
`endif
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign qspi_csb  = csb_q;
    assign qspi_sclk = sclk_q;
    assign qspi_do   = do_q;
    assign qspi_oe   = oe_q;

endmodule
